// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: constant words, state packing and the
// serial FSM encoding used by both the serial encoder and decoder.
package chacha20_pkg;

   localparam int BLOCK_BYTES = 64;

   localparam logic [31:0] SIGMA0 = 32'h61707865;
   localparam logic [31:0] SIGMA1 = 32'h3320646e;
   localparam logic [31:0] SIGMA2 = 32'h79622d32;
   localparam logic [31:0] SIGMA3 = 32'h6b206574;

   typedef enum logic [1:0] {IDLE, GEN, STREAM, DRAIN} state_e;

   // Word i of the 512-bit state lands at bits [32i+31:32i].
   function automatic logic [511:0] pack_state(input logic [255:0] key,
                                               input logic [31:0]  counter,
                                               input logic [95:0]  nonce);
      return {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
   endfunction

endpackage

// File: rtl/chacha20_block.sv
// Combinational ChaCha20 block function: 20 rounds plus the final
// feed-forward add of the input state.
module chacha20_block (
   input  logic [511:0] state_in,
   output logic [511:0] block_out
);

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                            input logic [31:0] c_in, input logic [31:0] d_in);
      logic [31:0] a, b, c, d;
      a = a_in; b = b_in; c = c_in; d = d_in;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   logic [31:0] x [16];

   always_comb begin
      for (int i = 0; i < 16; i++) x[i] = state_in[32*i +: 32];
      // Ten double rounds: one column pass then one diagonal pass.
      for (int r = 0; r < 10; r++) begin
         {x[0], x[4], x[8],  x[12]} = quarter(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = quarter(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = quarter(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = quarter(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = quarter(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = quarter(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = quarter(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = quarter(x[3], x[4], x[9],  x[14]);
      end
      block_out = '0;
      for (int i = 0; i < 16; i++) block_out[32*i +: 32] = x[i] + state_in[32*i +: 32];
   end

endmodule

// File: rtl/chacha20_serial_decoder.sv
// Byte-serial ChaCha20 decryptor: one keystream block per 64 bytes, a single
// output register, and a one-cycle GEN stall at every block boundary.
module chacha20_serial_decoder
   import chacha20_pkg::*;
(
   input  logic         clock,
   input  logic         clear_n,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  initial_counter,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [7:0]   out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         counter_wrapped
);

   state_e        state, state_nx;
   logic [255:0]  key_q;
   logic [95:0]   nonce_q;
   logic [31:0]   ctr_q;
   logic [5:0]    idx;
   logic [511:0]  ks_q, ks_nx, blk_state;
   logic          xfer, handoff, blk_end;

   assign blk_state = pack_state(key_q, ctr_q, nonce_q);

   chacha20_block u_block (
      .state_in  (blk_state),
      .block_out (ks_nx)
   );

   assign xfer    = in_valid && in_ready;
   assign handoff = out_valid && out_ready;
   // A last byte never triggers a new block, even when it is byte 63.
   assign blk_end = xfer && !in_last && (idx == 6'(BLOCK_BYTES - 1));

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE:   if (start) state_nx = GEN;
         GEN:    state_nx = STREAM;
         STREAM: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready) begin
               if (in_last)      state_nx = DRAIN;
               else if (blk_end) state_nx = GEN;
            end
         end
         DRAIN:  if (handoff) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         key_q           <= '0;
         nonce_q         <= '0;
         ctr_q           <= '0;
         idx             <= '0;
         ks_q            <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_last        <= 1'b0;
         busy            <= 1'b0;
         counter_wrapped <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            key_q           <= key;
            nonce_q         <= nonce;
            ctr_q           <= initial_counter;
            counter_wrapped <= 1'b0;
            busy            <= 1'b1;
         end
         if (state == GEN) begin
            ks_q <= ks_nx;
            idx  <= '0;
         end
         // A new byte overwrites the register even while the old one hands off.
         if (xfer) begin
            out_data  <= in_data ^ ks_q[{idx, 3'b000} +: 8];
            out_last  <= in_last;
            out_valid <= 1'b1;
            idx       <= idx + 6'd1;
         end else if (handoff) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (blk_end) begin
            ctr_q <= ctr_q + 32'd1;
            if (&ctr_q) counter_wrapped <= 1'b1;
         end
         if (state == DRAIN && handoff) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chacha20_serial_decoder.sv
module tb_chacha20_serial_decoder;
  import chacha20_pkg::*;

  logic         clock = 1'b0;
  logic         clear_n = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  initial_counter = '0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         counter_wrapped;

  int checks = 0;
  int failures = 0;
  bit bp_en = 0;
  bit gap_en = 0;

  logic [8:0]   exp_q[$];
  logic [7:0]   ct_buf[128];
  logic [7:0]   exp_buf[128];
  int           stall_cnt[128];
  logic         hold_pend = 1'b0;
  logic [7:0]   hold_val = '0;

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce = 96'h00000000_4a000000_00000000;
  string        rfc_pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  logic [7:0]   rfc_ct[114] = '{
    8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80, 8'h41, 8'hba, 8'h07, 8'h28, 8'hdd, 8'h0d, 8'h69, 8'h81,
    8'he9, 8'h7e, 8'h7a, 8'hec, 8'h1d, 8'h43, 8'h60, 8'hc2, 8'h0a, 8'h27, 8'haf, 8'hcc, 8'hfd, 8'h9f, 8'hae, 8'h0b,
    8'hf9, 8'h1b, 8'h65, 8'hc5, 8'h52, 8'h47, 8'h33, 8'hab, 8'h8f, 8'h59, 8'h3d, 8'hab, 8'hcd, 8'h62, 8'hb3, 8'h57,
    8'h16, 8'h39, 8'hd6, 8'h24, 8'he6, 8'h51, 8'h52, 8'hab, 8'h8f, 8'h53, 8'h0c, 8'h35, 8'h9f, 8'h08, 8'h61, 8'hd8,
    8'h07, 8'hca, 8'h0d, 8'hbf, 8'h50, 8'h0d, 8'h6a, 8'h61, 8'h56, 8'ha3, 8'h8e, 8'h08, 8'h8a, 8'h22, 8'hb6, 8'h5e,
    8'h52, 8'hbc, 8'h51, 8'h4d, 8'h16, 8'hcc, 8'hf8, 8'h06, 8'h81, 8'h8c, 8'he9, 8'h1a, 8'hb7, 8'h79, 8'h37, 8'h36,
    8'h5a, 8'hf9, 8'h0b, 8'hbf, 8'h74, 8'ha3, 8'h5b, 8'he6, 8'hb4, 8'h0b, 8'h8e, 8'hed, 8'hf2, 8'h78, 8'h5e, 8'h42,
    8'h87, 8'h4d};

  chacha20_serial_decoder dut (
    .clock           (clock),
    .clear_n         (clear_n),
    .start           (start),
    .key             (key),
    .nonce           (nonce),
    .initial_counter (initial_counter),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .busy            (busy),
    .counter_wrapped (counter_wrapped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] n);
    logic [31:0] s[16], w[16];
    int t[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    w = s;
    for (int rd = 0; rd < 10; rd++)
      for (int q = 0; q < 8; q++) begin
        w[t[q][0]] += w[t[q][1]]; w[t[q][3]] = rl(w[t[q][3]] ^ w[t[q][0]], 16);
        w[t[q][2]] += w[t[q][3]]; w[t[q][1]] = rl(w[t[q][1]] ^ w[t[q][2]], 12);
        w[t[q][0]] += w[t[q][1]]; w[t[q][3]] = rl(w[t[q][3]] ^ w[t[q][0]], 8);
        w[t[q][2]] += w[t[q][3]]; w[t[q][1]] = rl(w[t[q][1]] ^ w[t[q][2]], 7);
      end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  always @(negedge clock) begin
    if (clear_n) begin
      if (hold_pend && out_valid) begin
        checks++;
        if (out_data !== hold_val) begin
          failures++;
          $error("FAIL hold_data: observed %0h expected %0h", out_data, hold_val);
        end
      end
      hold_pend <= out_valid && !out_ready;
      hold_val  <= out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow: observed %0h expected %0h", out_data, 0);
        end else begin
          checks++;
          if (out_data !== exp_q[0][7:0]) begin
            failures++;
            $error("FAIL out_data: observed %0h expected %0h", out_data, exp_q[0][7:0]);
          end
          checks++;
          if (out_last !== exp_q[0][8]) begin
            failures++;
            $error("FAIL out_last: observed %0h expected %0h", out_last, exp_q[0][8]);
          end
          void'(exp_q.pop_front());
        end
      end
    end else hold_pend <= 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 2) != 0);
    else       out_ready = 1'b1;
  endtask

  task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; initial_counter = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_rfc();
    for (int i = 0; i < 114; i++) begin
      ct_buf[i]  = rfc_ct[i];
      exp_buf[i] = rfc_pt[i];
    end
  endtask

  task automatic fill_model(input logic [255:0] k, input logic [95:0] n,
                            input logic [31:0] c, input int len);
    logic [511:0] blk;
    for (int i = 0; i < len; i++) begin
      ct_buf[i]  = 8'(i * 37 + 11);
      blk        = ref_block(k, c + 32'(i / 64), n);
      exp_buf[i] = ct_buf[i] ^ blk[8*(i % 64) +: 8];
    end
  endtask

  task automatic stream(input int from, input int to, input int len);
    int stall;
    bit acc;
    for (int i = from; i < to; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1; in_data = ct_buf[i]; in_last = (i == len - 1);
      stall = 0; acc = 0;
      while (!acc) begin
        @(negedge clock);
        if (in_ready) begin
          acc = 1;
          exp_q.push_back({in_last, exp_buf[i]});
        end else begin
          stall++;
          if (stall > 500) begin
            chk("in_ready_timeout", in_ready, 1'b1);
            acc = 1;
          end
        end
        tick();
      end
      stall_cnt[i] = stall;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);

    #2 clear_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrapped", counter_wrapped, 1'b0);
    repeat (2) @(posedge clock);
    #1 clear_n = 1'b1;
    tick();

    fill_rfc();
    do_start(rfc_key, rfc_nonce, 32'd1);
    stream(0, 114, 114);
    wait_idle("rfc_idle");
    chk("rfc_gen_stall", stall_cnt[64], 1);
    chk("rfc_no_stall63", stall_cnt[63], 0);
    chk("rfc_ctr_end", dut.ctr_q, 32'd2);
    chk("rfc_no_wrap", counter_wrapped, 1'b0);

    bp_en = 1; gap_en = 1;
    do_start(rfc_key, rfc_nonce, 32'd1);
    stream(0, 114, 114);
    wait_idle("bp_idle");
    chk("bp_ctr_end", dut.ctr_q, 32'd2);
    bp_en = 0; gap_en = 0;
    tick();

    fill_model(~rfc_key, 96'h0123456789abcdef01234567, 32'd5, 64);
    do_start(~rfc_key, 96'h0123456789abcdef01234567, 32'd5);
    stream(0, 64, 64);
    chk("b64_drain_ready", in_ready, 1'b0);
    chk("b64_drain_busy", busy, 1'b1);
    chk("b64_drain_state", dut.state, DRAIN);
    tick();
    chk("b64_busy_low", busy, 1'b0);
    chk("b64_idle", dut.state, IDLE);
    chk("b64_ctr", dut.ctr_q, 32'd5);
    wait_idle("b64_wait");

    fill_model(rfc_key, rfc_nonce, 32'hffffffff, 65);
    do_start(rfc_key, rfc_nonce, 32'hffffffff);
    chk("wrap_pre", counter_wrapped, 1'b0);
    stream(0, 64, 65);
    chk("wrap_set", counter_wrapped, 1'b1);
    stream(64, 65, 65);
    wait_idle("wrap_idle");
    chk("wrap_ctr", dut.ctr_q, 32'd0);
    chk("wrap_sticky", counter_wrapped, 1'b1);

    fill_rfc();
    do_start(rfc_key, rfc_nonce, 32'd1);
    chk("wrap_cleared", counter_wrapped, 1'b0);
    stream(0, 30, 114);
    key = ~rfc_key; initial_counter = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_busy", busy, 1'b1);
    chk("sb_key", dut.key_q, rfc_key);
    stream(30, 114, 114);
    wait_idle("sb_idle");

    do_start(rfc_key, rfc_nonce, 32'd1);
    stream(0, 20, 114);
    clear_n = 1'b0;
    #1;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_out_data", out_data, 8'h00);
    chk("clr_out_last", out_last, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_in_ready", in_ready, 1'b0);
    chk("clr_state", dut.state, IDLE);
    exp_q.delete();
    tick();
    clear_n = 1'b1;
    tick();
    do_start(rfc_key, rfc_nonce, 32'd1);
    stream(0, 114, 114);
    wait_idle("post_clr_idle");
    chk("post_clr_ctr", dut.ctr_q, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chacha20_serial_decoder.md
Name: chacha20_serial_decoder

Overview:
- Streaming ChaCha20 (RFC 8439) decryptor: accepts ciphertext one byte per beat, outputs plaintext one byte per beat.
- Is the receive-side counterpart of the serial encoder and uses the same keystream generator (chacha20_block).
- A message is key + nonce + initial block counter, loaded on start, then a byte stream terminated by in_last.

Parameters:
- none (block size fixed at 64 bytes, 512-bit state)

Ports:
clock  input  1  system clock, rising edge
clear_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches key/nonce/initial_counter when idle
key  input  256  key; key[31:0] = state word 4, key[255:224] = word 11
nonce  input  96  nonce; nonce[31:0] = word 13, nonce[95:64] = word 15
initial_counter  input  32  block counter for first keystream block (word 12)
in_valid  input  1  ciphertext byte valid
in_data  input  8  ciphertext byte
in_last  input  1  marks final byte of message
in_ready  output  1  decoder accepts in_data this cycle
out_valid  output  1  plaintext byte valid
out_data  output  8  plaintext byte
out_last  output  1  final plaintext byte
out_ready  input  1  downstream accepts out_data
busy  output  1  high from accepted start until final byte leaves
counter_wrapped  output  1  sticky; set when the block counter wraps 0xFFFFFFFF->0 within a message

Behaviour:
- Reset (clear_n low, async): state IDLE. in_ready, out_valid, out_last, busy and counter_wrapped are all 0. out_data is 0. Internal counter, byte index and keystream register are all 0.
- Words 0-3 of the state: 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Word i sits at round_input[32i+31:32i].
- IDLE: start=1 latches key, nonce and initial_counter. It also clears counter_wrapped, asserts busy and moves to GEN. start outside IDLE is ignored.
- GEN (exactly 1 cycle): keystream register <= chacha20_block(state). Byte index <= 0. Next state is STREAM.
- STREAM:
  - in_ready = !out_valid || out_ready (single output register, no bubble at full rate).
  - On an in_valid && in_ready transfer: out_data <= in_data ^ ks[8*idx+7:8*idx], out_last <= in_last, out_valid <= 1, idx++.
  - If in_last is transferred: go to DRAIN, regardless of idx.
  - Else if idx was 63: counter <= counter+1 and go to GEN. If counter was 0xFFFFFFFF it wraps to 0 and counter_wrapped <= 1.
  - in_last on byte 63 does not increment the counter.
- DRAIN: in_ready=0. When out_valid && out_ready, clear out_valid and out_last, deassert busy and go to IDLE.
- out_valid clears on out_ready whenever no new transfer occurs in the same cycle. Simultaneous output handoff and input transfer keeps out_valid=1 with the new byte.
- Latency: start to first in_ready is 2 cycles. Input byte to out_valid is 1 cycle. Each block boundary inserts exactly 1 stall cycle (GEN).
- out_data is held stable while out_valid && !out_ready. in_data/in_last are ignored without in_ready.
- clear_n asserted mid-message aborts immediately to the reset values. Any partial message is lost.
- Zero-length messages are not supported. Every message carries at least one byte with in_last.

Decomposition:
- Shared package chacha20_pkg:
  - the four constant words
  - state-word packing function (key, counter, nonce -> 512-bit state)
  - FSM state enum {IDLE, GEN, STREAM, DRAIN}
  - BLOCK_BYTES=64
- The packing function is shared with the serial encoder.
- Sub-module: existing chacha20_block, used as a combinational generator and instantiated once.
- Everything else (FSM, index counter, output register) lives in chacha20_serial_decoder.

Test Plan:
- RFC 8439 §2.4.2 vector: key 00..1f, nonce 00 00 00 00 00 00 00 4a 00 00 00 00, counter 1. Ciphertext 6e 2e 35 9a -> plaintext 4c 61 64 69 ("Ladi"). The full 114-byte ciphertext -> "Ladies and Gentlemen of the class of '99...". out_last is on byte 114, exactly one GEN stall after byte 64, and the internal counter ends at 2.
- Backpressure: same vector with out_ready toggled pseudo-randomly and in_valid gapped. Output bytes are identical and in order. out_data is held while stalled. No byte is dropped or duplicated.
- Exact 64-byte message with in_last on byte 64 -> no GEN after the last byte. DRAIN then IDLE, busy=0 one cycle after the final handoff. Counter is not incremented.
- Wrap: initial_counter=0xFFFFFFFF, 65-byte message -> counter_wrapped=1 after byte 64. Byte 65 is XORed with the counter-0 keystream byte 0. The flag clears on the next start.
- Start while busy is ignored (key unchanged, output unchanged). clear_n pulsed mid-STREAM -> all outputs 0 asynchronously, state IDLE. A fresh start then decodes the RFC vector correctly.
